// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_writeback_arbiter
//  Function : Register-file write-port master. Merges the non-stalling ALU
//             writeback with a FIFO-buffered long-latency result stream and
//             exposes pending/forward lookups for decode.
//             Optional macro RF_WB_FORWARD_EN enables the forward-data muxes.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      alu_wr_en,
   input  logic [ADDR_W-1:0]         alu_wr_addr,
   input  logic [DATA_W-1:0]         alu_wr_data,
   input  logic                      lr_valid,
   input  logic [ADDR_W-1:0]         lr_addr,
   input  logic [DATA_W-1:0]         lr_data,
   output logic                      lr_ready,
   output logic                      rf_RegWrite,
   output logic [ADDR_W-1:0]         rf_WriteReg,
   output logic [DATA_W-1:0]         rf_WriteData,
   input  logic [ADDR_W-1:0]         rs_addr,
   input  logic [ADDR_W-1:0]         rt_addr,
   output logic                      rs_pending,
   output logic                      rt_pending,
   output logic [DATA_W-1:0]         rs_fwd_data,
   output logic [DATA_W-1:0]         rt_fwd_data,
   output logic [$clog2(DEPTH):0]    fifo_count
);

   localparam int               c_PTR_W = $clog2(DEPTH);
   localparam int               c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL = DEPTH[c_CNT_W-1:0];

   logic [ADDR_W-1:0]  r_fifo_addr [DEPTH];
   logic [DATA_W-1:0]  r_fifo_data [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic               r_reg_write;
   logic [ADDR_W-1:0]  r_write_reg;
   logic [DATA_W-1:0]  r_write_data;

   logic               w_alu_take;
   logic               w_push;
   logic               w_pop;

   assign lr_ready     = (r_count < c_FULL);
   assign fifo_count   = r_count;
   assign rf_RegWrite  = r_reg_write;
   assign rf_WriteReg  = r_write_reg;
   assign rf_WriteData = r_write_data;

   // ALU writes to r0 are dropped and leave the port free for the FIFO.
   always_comb begin
      w_alu_take = alu_wr_en && (alu_wr_addr != '0);
      w_pop      = !w_alu_take && (r_count != '0);
      w_push     = lr_valid && lr_ready && (lr_addr != '0);
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= lr_addr;
         r_fifo_data[r_wr_ptr] <= lr_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_reg_write  <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase

         if (w_alu_take) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= alu_wr_addr;
            r_write_data <= alu_wr_data;
         end else if (w_pop) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= r_fifo_addr[r_rd_ptr];
            r_write_data <= r_fifo_data[r_rd_ptr];
         end else begin
            r_reg_write  <= 1'b0;
         end
      end
   end

   // Pending flags: output stage or any live FIFO entry targeting the source.
   logic [c_PTR_W-1:0] w_pidx;
   always_comb begin
      rs_pending = r_reg_write && (rs_addr != '0) && (r_write_reg == rs_addr);
      rt_pending = r_reg_write && (rt_addr != '0) && (r_write_reg == rt_addr);
      w_pidx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_pidx = r_rd_ptr + c_PTR_W'(k);
         if (c_CNT_W'(k) < r_count) begin
            if ((rs_addr != '0) && (r_fifo_addr[w_pidx] == rs_addr)) rs_pending = 1'b1;
            if ((rt_addr != '0) && (r_fifo_addr[w_pidx] == rt_addr)) rt_pending = 1'b1;
         end
      end
   end

`ifdef RF_WB_FORWARD_EN
   // Walk oldest to youngest so the youngest match wins over older ones.
   logic [c_PTR_W-1:0] w_fidx;
   logic [DATA_W-1:0]  w_rs_data;
   logic [DATA_W-1:0]  w_rt_data;
   always_comb begin
      w_rs_data = '0;
      w_rt_data = '0;
      w_fidx    = '0;
      if (r_reg_write && (rs_addr != '0) && (r_write_reg == rs_addr)) w_rs_data = r_write_data;
      if (r_reg_write && (rt_addr != '0) && (r_write_reg == rt_addr)) w_rt_data = r_write_data;
      for (int k = 0; k < DEPTH; k++) begin
         w_fidx = r_rd_ptr + c_PTR_W'(k);
         if (c_CNT_W'(k) < r_count) begin
            if ((rs_addr != '0) && (r_fifo_addr[w_fidx] == rs_addr)) w_rs_data = r_fifo_data[w_fidx];
            if ((rt_addr != '0) && (r_fifo_addr[w_fidx] == rt_addr)) w_rt_data = r_fifo_data[w_fidx];
         end
      end
   end
   assign rs_fwd_data = w_rs_data;
   assign rt_fwd_data = w_rt_data;
`else
   assign rs_fwd_data = '0;
   assign rt_fwd_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_writeback_arbiter
//  Function : Directed scoreboard bench for rf_writeback_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_writeback_arbiter;

   logic        clock;
   logic        reset;
   logic        alu_wr_en;
   logic [4:0]  alu_wr_addr;
   logic [31:0] alu_wr_data;
   logic        lr_valid;
   logic [4:0]  lr_addr;
   logic [31:0] lr_data;
   logic        lr_ready;
   logic        rf_RegWrite;
   logic [4:0]  rf_WriteReg;
   logic [31:0] rf_WriteData;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        rs_pending;
   logic        rt_pending;
   logic [31:0] rs_fwd_data;
   logic [31:0] rt_fwd_data;
   logic [2:0]  fifo_count;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  checks   = 0;
   int  failures = 0;

   rf_writeback_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clock        (clock),
      .reset        (reset),
      .alu_wr_en    (alu_wr_en),
      .alu_wr_addr  (alu_wr_addr),
      .alu_wr_data  (alu_wr_data),
      .lr_valid     (lr_valid),
      .lr_addr      (lr_addr),
      .lr_data      (lr_data),
      .lr_ready     (lr_ready),
      .rf_RegWrite  (rf_RegWrite),
      .rf_WriteReg  (rf_WriteReg),
      .rf_WriteData (rf_WriteData),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_pending   (rs_pending),
      .rt_pending   (rt_pending),
      .rs_fwd_data  (rs_fwd_data),
      .rt_fwd_data  (rt_fwd_data),
      .fifo_count   (fifo_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      alu_wr_en = 1'b0; alu_wr_addr = '0; alu_wr_data = '0;
      lr_valid  = 1'b0; lr_addr     = '0; lr_data     = '0;
   endtask

   // Monitor: every register-file write must match the scoreboard head.
   initial begin
      wr_t e;
      forever begin
         @(negedge clock);
         if (reset === 1'b1 && rf_RegWrite === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write: got reg=%0d data=0x%0h expected no write",
                        rf_WriteReg, rf_WriteData);
            end else begin
               e = sb.pop_front();
               if (rf_WriteReg !== e.addr || rf_WriteData !== e.data) begin
                  failures++;
                  $display("FAIL write_order: got reg=%0d data=0x%0h expected reg=%0d data=0x%0h",
                           rf_WriteReg, rf_WriteData, e.addr, e.data);
               end
            end
         end
      end
   end

   logic [31:0] exp_fwd22;
   logic [31:0] exp_fwdf2;

   initial begin
`ifdef RF_WB_FORWARD_EN
      exp_fwd22 = 32'h22;
      exp_fwdf2 = 32'hF2;
`else
      exp_fwd22 = 32'h0;
      exp_fwdf2 = 32'h0;
`endif
      reset = 1'b0;
      rs_addr = '0;
      rt_addr = '0;
      idle_inputs();
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // Reset with two queued entries held behind ALU traffic
      alu_wr_en = 1'b1; alu_wr_addr = 5'd1; alu_wr_data = 32'hA1;
      lr_valid  = 1'b1; lr_addr     = 5'd2; lr_data     = 32'hB2;
      expect_wr(5'd1, 32'hA1);
      tick();
      alu_wr_data = 32'hA2;
      lr_addr = 5'd3; lr_data = 32'hB3;
      tick();
      check("pre_reset_count", fifo_count, 3'd2);
      reset = 1'b0;
      idle_inputs();
      sb.delete();
      repeat (2) tick();
      reset = 1'b1;
      #1;
      check("rst_count",     fifo_count,   3'd0);
      check("rst_lr_ready",  lr_ready,     1'b1);
      check("rst_regwrite",  rf_RegWrite,  1'b0);
      check("rst_writereg",  rf_WriteReg,  5'd0);
      check("rst_writedata", rf_WriteData, 32'd0);
      repeat (3) tick();
      check("post_rst_count", fifo_count, 3'd0);

      // ALU path: one write, one cycle only
      alu_wr_en = 1'b1; alu_wr_addr = 5'd3; alu_wr_data = 32'h55;
      expect_wr(5'd3, 32'h55);
      tick();
      check("alu_regwrite", rf_RegWrite, 1'b1);
      check("alu_writereg", rf_WriteReg, 5'd3);
      idle_inputs();
      tick();
      check("alu_single_cycle", rf_RegWrite, 1'b0);

      // Fill to full while the ALU owns the port
      for (int i = 0; i < 4; i++) begin
         alu_wr_en = 1'b1; alu_wr_addr = 5'(10 + i); alu_wr_data = 32'(32'h100 + i);
         lr_valid  = 1'b1; lr_addr     = 5'(4 + i);  lr_data     = 32'(32'h40 + i);
         expect_wr(5'(10 + i), 32'(32'h100 + i));
         tick();
      end
      check("full_count", fifo_count, 3'd4);
      check("full_ready", lr_ready,   1'b0);
      alu_wr_en = 1'b0;
      lr_addr = 5'd8; lr_data = 32'h88;
      for (int i = 0; i < 4; i++) expect_wr(5'(4 + i), 32'(32'h40 + i));
      tick();
      check("after_pop_count", fifo_count, 3'd3);
      check("after_pop_ready", lr_ready,   1'b1);
      idle_inputs();
      repeat (3) tick();
      check("drained_count", fifo_count, 3'd0);
      tick();
      check("drained_idle", rf_RegWrite, 1'b0);

      // Register-0 filtering
      lr_valid = 1'b1; lr_addr = 5'd0; lr_data = 32'h99;
      check("r0_handshake_ready", lr_ready, 1'b1);
      tick();
      check("r0_push_count", fifo_count, 3'd0);
      lr_addr = 5'd20; lr_data = 32'h20;
      alu_wr_en = 1'b1; alu_wr_addr = 5'd0; alu_wr_data = 32'hDEAD;
      tick();
      check("r0_alu_nowrite", rf_RegWrite, 1'b0);
      lr_valid = 1'b0;
      expect_wr(5'd20, 32'h20);
      tick();
      check("r0_alu_fifo_wr",  rf_RegWrite, 1'b1);
      check("r0_alu_fifo_reg", rf_WriteReg, 5'd20);
      check("r0_alu_count",    fifo_count,  3'd0);
      idle_inputs();
      tick();

      // Pending and forwarding
      alu_wr_en = 1'b1; alu_wr_addr = 5'd15; alu_wr_data = 32'hF1;
      lr_valid  = 1'b1; lr_addr     = 5'd9;  lr_data     = 32'h11;
      expect_wr(5'd15, 32'hF1);
      tick();
      alu_wr_data = 32'hF2; lr_data = 32'h22;
      expect_wr(5'd15, 32'hF2);
      tick();
      lr_valid = 1'b0;
      alu_wr_addr = 5'd16; alu_wr_data = 32'hF3;
      expect_wr(5'd16, 32'hF3);
      rs_addr = 5'd9; rt_addr = 5'd0;
      #1;
      check("rs_pending_fifo", rs_pending,  1'b1);
      check("rs_fwd_youngest", rs_fwd_data, exp_fwd22);
      check("rt_pending_r0",   rt_pending,  1'b0);
      check("rt_fwd_r0",       rt_fwd_data, 32'h0);
      rt_addr = 5'd15;
      #1;
      check("rt_pending_outstage", rt_pending,  1'b1);
      check("rt_fwd_outstage",     rt_fwd_data, exp_fwdf2);
      rt_addr = 5'd12;
      tick();
      check("hold_count", fifo_count, 3'd2);

      // Simultaneous push and pop
      alu_wr_en = 1'b0;
      lr_valid = 1'b1; lr_addr = 5'd12; lr_data = 32'hC0;
      expect_wr(5'd9, 32'h11);
      tick();
      check("pushpop_count", fifo_count, 3'd2);
      check("pushpop_fwd_prio", rs_fwd_data, exp_fwd22);
      check("rt_pending_new", rt_pending, 1'b1);
      idle_inputs();
      expect_wr(5'd9, 32'h22);
      expect_wr(5'd12, 32'hC0);
      repeat (3) tick();
      check("final_count",      fifo_count, 3'd0);
      check("final_rs_pending", rs_pending, 1'b0);
      check("final_rt_pending", rt_pending, 1'b0);
      repeat (2) tick();
      check("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
